// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampled UART receiver with configurable data width, parity and stop bits.
// Define UART_RX_MAJORITY_EN to take every bit as a 2-of-3 vote around the mid sample.
module uart_rx_cfg #(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_out_o,
    output logic                 data_valid_o,
    input  logic                 data_ready_i,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 overrun_err_o,
    output logic                 busy_o
);
    localparam int unsigned DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IDX_W = $clog2(OVERSAMPLE);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e               state_q, state_d;
    logic                 rx_meta_q, rx_s_q, rx_prev_q;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 pout_q, pout_d;
    logic                 fout_q, fout_d;
    logic                 valid_q, valid_d;
    logic                 ovr_q, ovr_d;
    logic                 tick, mid, bit_end, accept, bit_val;

    assign tick    = (state_q != StIdle) && (div_q == DIV_W'(DIV - 1));
    assign bit_end = tick && (idx_q == IDX_W'(OVERSAMPLE - 1));
    assign accept  = valid_q && data_ready_i;

`ifdef UART_RX_MAJORITY_EN
    // The decision lands on the third vote, one tick after the nominal mid point.
    localparam int unsigned MID_IDX = OVERSAMPLE / 2;
    logic [1:0] vote_q, vote_d;

    always_comb begin
        vote_d = vote_q;
        if (tick && idx_q == IDX_W'(OVERSAMPLE / 2 - 2)) vote_d[0] = rx_s_q;
        if (tick && idx_q == IDX_W'(OVERSAMPLE / 2 - 1)) vote_d[1] = rx_s_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vote_q <= 2'b11;
        else        vote_q <= vote_d;
    end

    assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s_q) | (vote_q[1] & rx_s_q);
`else
    localparam int unsigned MID_IDX = OVERSAMPLE / 2 - 1;
    assign bit_val = rx_s_q;
`endif

    assign mid = tick && (idx_q == IDX_W'(MID_IDX));

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        idx_d     = idx_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        dout_d    = dout_q;
        pout_d    = pout_q;
        fout_d    = fout_q;
        valid_d   = valid_q;
        ovr_d     = 1'b0;

        if (accept) valid_d = 1'b0;

        if (state_q != StIdle) begin
            if (tick) begin
                div_d = '0;
                idx_d = (idx_q == IDX_W'(OVERSAMPLE - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                // Requiring prev=1 keeps a held-low line from retriggering after a break.
                if (rx_prev_q && !rx_s_q) begin
                    state_d   = StStart;
                    div_d     = '0;
                    idx_d     = '0;
                    bit_cnt_d = '0;
                    perr_d    = 1'b0;
                    ferr_d    = 1'b0;
                end
            end
            StStart: begin
                if (mid && bit_val)  state_d = StIdle;
                else if (bit_end)    state_d = StData;
            end
            StData: begin
                if (mid) shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                if (bit_end) begin
                    if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            StParity: begin
                if (mid)     perr_d  = bit_val != ((^shift_q) ^ (PARITY == 1));
                if (bit_end) state_d = StStop;
            end
            StStop: begin
                if (mid) begin
                    if (!bit_val) ferr_d = 1'b1;
                    if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                        state_d = StIdle;
                        if (!valid_q || accept) begin
                            dout_d  = shift_q;
                            pout_d  = perr_q;
                            fout_d  = ferr_q | ~bit_val;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end
                end
                if (bit_end) bit_cnt_d = bit_cnt_q + 4'd1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= StIdle;
            div_q     <= '0;
            idx_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            dout_q    <= '0;
            pout_q    <= 1'b0;
            fout_q    <= 1'b0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            state_q   <= state_d;
            div_q     <= div_d;
            idx_q     <= idx_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            dout_q    <= dout_d;
            pout_q    <= pout_d;
            fout_q    <= fout_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
        end
    end

    assign data_out_o    = dout_q;
    assign data_valid_o  = valid_q;
    assign parity_err_o  = (PARITY == 0) ? 1'b0 : pout_q;
    assign frame_err_o   = fout_q;
    assign overrun_err_o = ovr_q;
    assign busy_o        = (state_q != StIdle);

endmodule
